// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared Ethernet framing types and constants
package eth_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREAMBLE = 3'd1,
        ST_SFD      = 3'd2,
        ST_DATA     = 3'd3,
        ST_PAD      = 3'd4,
        ST_FCS      = 3'd5,
        ST_DRAIN    = 3'd6,
        ST_IFG      = 3'd7
    } tx_state_e;

    localparam int          PREAMBLE_LEN  = 7;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

endpackage

// File: rtl/gmii_tx_framer_if.sv
// rtl/gmii_tx_framer_if.sv - byte stream into the GMII transmit framer
interface gmii_tx_framer_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (output tdata, output tvalid, output tlast, output tuser, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tuser, output tready);
endinterface

// File: rtl/eth_crc32_d8.sv
// rtl/eth_crc32_d8.sv - one-byte step of reflected CRC-32, shared by TX and RX
module eth_crc32_d8
    import eth_pkg::*;
(
    input  logic [7:0]  data,
    input  logic [31:0] crc_in,
    output logic [31:0] crc_out
);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'd0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC32_POLY) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/gmii_tx_framer.sv
// rtl/gmii_tx_framer.sv - frames a byte stream onto GMII with preamble, pad, FCS and IFG
module gmii_tx_framer
    import eth_pkg::*;
#(
    parameter int unsigned IFG_BYTES      = 12,
    parameter int unsigned MIN_DATA_BYTES = 60
) (
    input  logic            gmii_tx_clk,
    input  logic            reset,
    gmii_tx_framer_if.slave s_axis,
    output logic [7:0]      gmii_txd,
    output logic            gmii_tx_en,
    output logic            gmii_tx_er,
    output logic            frame_done,
    output logic            frame_err
);

    localparam int                CNT_W    = $clog2(MIN_DATA_BYTES + 1);
    localparam int                AUX_W    = 16;
    localparam logic [CNT_W-1:0]  MIN_CNT  = CNT_W'(MIN_DATA_BYTES);
    localparam logic [AUX_W-1:0]  PRE_LAST = AUX_W'(PREAMBLE_LEN - 1);
    localparam logic [AUX_W-1:0]  FCS_LAST = AUX_W'(3);
    localparam logic [AUX_W-1:0]  IFG_LAST = AUX_W'(IFG_BYTES - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] data_cnt_q, data_cnt_d;
    logic [AUX_W-1:0] aux_cnt_q, aux_cnt_d;
    logic [31:0]      crc_q, crc_d;
    logic             err_q, err_d;
    logic [7:0]       txd_q, txd_d;
    logic             tx_en_q, tx_en_d;
    logic             tx_er_q, tx_er_d;
    logic             done_q, done_d;
    logic             ferr_q, ferr_d;

    logic [7:0]       crc_byte;
    logic [31:0]      crc_next;
    logic [31:0]      fcs_shift;
    logic [CNT_W-1:0] cnt_inc, cnt_sat;

    assign s_axis.tready = (state_q == ST_DATA) || (state_q == ST_DRAIN);

    // Pad bytes are zero, so the CRC input only needs the stream byte in DATA.
    assign crc_byte  = (state_q == ST_DATA) ? s_axis.tdata : 8'h00;
    assign fcs_shift = crc_q >> {aux_cnt_q[1:0], 3'b000};
    assign cnt_inc   = data_cnt_q + CNT_W'(1);
    assign cnt_sat   = (data_cnt_q == MIN_CNT) ? data_cnt_q : cnt_inc;

    eth_crc32_d8 u_crc (
        .data    (crc_byte),
        .crc_in  (crc_q),
        .crc_out (crc_next)
    );

    always_ff @(posedge gmii_tx_clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            data_cnt_q <= '0;
            aux_cnt_q  <= '0;
            crc_q      <= CRC32_INIT;
            err_q      <= 1'b0;
            txd_q      <= 8'h00;
            tx_en_q    <= 1'b0;
            tx_er_q    <= 1'b0;
            done_q     <= 1'b0;
            ferr_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_cnt_q <= data_cnt_d;
            aux_cnt_q  <= aux_cnt_d;
            crc_q      <= crc_d;
            err_q      <= err_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            tx_er_q    <= tx_er_d;
            done_q     <= done_d;
            ferr_q     <= ferr_d;
        end
    end

    // The first preamble byte leaves from IDLE, so PREAMBLE itself sends six.
    always_comb begin
        state_d    = state_q;
        data_cnt_d = data_cnt_q;
        aux_cnt_d  = aux_cnt_q;
        err_d      = err_q;
        case (state_q)
            ST_IDLE: begin
                if (s_axis.tvalid) begin
                    state_d    = ST_PREAMBLE;
                    aux_cnt_d  = AUX_W'(1);
                    data_cnt_d = '0;
                    err_d      = 1'b0;
                end
            end
            ST_PREAMBLE: begin
                aux_cnt_d = aux_cnt_q + AUX_W'(1);
                if (aux_cnt_q == PRE_LAST) state_d = ST_SFD;
            end
            ST_SFD: begin
                state_d   = ST_DATA;
                aux_cnt_d = '0;
            end
            ST_DATA: begin
                if (s_axis.tvalid) begin
                    data_cnt_d = cnt_sat;
                    if (s_axis.tuser) err_d = 1'b1;
                    if (s_axis.tlast) state_d = (cnt_sat < MIN_CNT) ? ST_PAD : ST_FCS;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_PAD: begin
                data_cnt_d = cnt_inc;
                if (cnt_inc == MIN_CNT) state_d = ST_FCS;
            end
            ST_FCS: begin
                aux_cnt_d = aux_cnt_q + AUX_W'(1);
                if (aux_cnt_q == FCS_LAST) begin
                    state_d   = ST_IFG;
                    aux_cnt_d = '0;
                end
            end
            ST_DRAIN: begin
                if (s_axis.tvalid && s_axis.tlast) begin
                    state_d   = ST_IFG;
                    aux_cnt_d = '0;
                end
            end
            ST_IFG: begin
                aux_cnt_d = aux_cnt_q + AUX_W'(1);
                if (aux_cnt_q == IFG_LAST) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        txd_d   = 8'h00;
        tx_en_d = 1'b0;
        tx_er_d = 1'b0;
        crc_d   = crc_q;
        done_d  = 1'b0;
        ferr_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (s_axis.tvalid) begin
                    txd_d   = PREAMBLE_BYTE;
                    tx_en_d = 1'b1;
                end
            end
            ST_PREAMBLE: begin
                txd_d   = PREAMBLE_BYTE;
                tx_en_d = 1'b1;
            end
            ST_SFD: begin
                txd_d   = SFD_BYTE;
                tx_en_d = 1'b1;
                crc_d   = CRC32_INIT;
            end
            ST_DATA: begin
                tx_en_d = 1'b1;
                if (s_axis.tvalid) begin
                    txd_d   = s_axis.tdata;
                    tx_er_d = s_axis.tuser;
                    crc_d   = crc_next;
                end else begin
                    tx_er_d = 1'b1;
                end
            end
            ST_PAD: begin
                tx_en_d = 1'b1;
                crc_d   = crc_next;
            end
            ST_FCS: begin
                txd_d   = ~fcs_shift[7:0];
                tx_en_d = 1'b1;
            end
            default: ;
        endcase
        if ((state_d == ST_IFG) && (state_q != ST_IFG)) begin
            done_d = ~err_d;
            ferr_d = err_d;
        end
    end

    assign gmii_txd   = txd_q;
    assign gmii_tx_en = tx_en_q;
    assign gmii_tx_er = tx_er_q;
    assign frame_done = done_q;
    assign frame_err  = ferr_q;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// tb/tb_gmii_tx_framer.sv - self-checking bench for gmii_tx_framer
module tb_gmii_tx_framer;
    import eth_pkg::*;

    typedef logic [7:0] u8;
    localparam int IFG = 12;
    localparam int MIN = 60;
    localparam int LIMIT = 3000;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    gmii_tx_framer_if sif ();
    logic [7:0] gmii_txd;
    logic       gmii_tx_en, gmii_tx_er, frame_done, frame_err;

    gmii_tx_framer #(.IFG_BYTES(IFG), .MIN_DATA_BYTES(MIN)) dut (
        .gmii_tx_clk (clk),
        .reset       (reset),
        .s_axis      (sif),
        .gmii_txd    (gmii_txd),
        .gmii_tx_en  (gmii_tx_en),
        .gmii_tx_er  (gmii_tx_er),
        .frame_done  (frame_done),
        .frame_err   (frame_err)
    );

    int n_checks = 0;
    int n_err = 0;
    u8  tx_data[$];
    u8  exp_b[$];
    u8  cap[$];
    bit exp_er[$];
    bit cap_er[$];
    bit exp_err;
    int gaps[$];
    int cyc = 0, start_cyc = 0, rise_cyc = -1, zero_run = 0;
    int done_cnt = 0, err_cnt = 0;
    bit prev_en = 1'b0;

    typedef struct {
        int  len;
        u8   first;
        int  user_idx;
        int  drop_at;
        int  exp_en;
        bit  exp_err;
    } vec_t;
    vec_t vecs[7];

    always @(posedge clk) begin
        #1;
        cyc++;
        if (gmii_tx_en) begin
            cap.push_back(gmii_txd);
            cap_er.push_back(gmii_tx_er);
            if (!prev_en) begin
                rise_cyc = cyc;
                gaps.push_back(zero_run);
            end
            zero_run = 0;
        end else begin
            zero_run++;
        end
        prev_en = gmii_tx_en;
        if (frame_done) done_cnt++;
        if (frame_err) err_cnt++;
    end

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc32_of(input u8 q[$], input int from);
        logic [31:0] c = 32'hFFFFFFFF;
        for (int i = from; i < q.size(); i++) begin
            c = c ^ {24'd0, q[i]};
            for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return c;
    endfunction

    // Expected GMII bytes straight from the framing rules.
    task automatic build_model(input int user_idx, input int drop_at);
        u8 body[$];
        logic [31:0] inv;
        exp_b.delete();
        exp_er.delete();
        for (int i = 0; i < 7; i++) begin exp_b.push_back(8'h55); exp_er.push_back(1'b0); end
        exp_b.push_back(8'hD5); exp_er.push_back(1'b0);
        if (drop_at >= 0) begin
            for (int i = 0; i < drop_at; i++) begin
                exp_b.push_back(tx_data[i]);
                exp_er.push_back(i == user_idx);
            end
            exp_b.push_back(8'h00); exp_er.push_back(1'b1);
            exp_err = 1'b1;
        end else begin
            body = tx_data;
            while (body.size() < MIN) body.push_back(8'h00);
            inv = ~crc32_of(body, 0);
            for (int i = 0; i < body.size(); i++) begin
                exp_b.push_back(body[i]);
                exp_er.push_back(i == user_idx);
            end
            for (int k = 0; k < 4; k++) begin
                exp_b.push_back(inv[8*k +: 8]);
                exp_er.push_back(1'b0);
            end
            exp_err = (user_idx >= 0);
        end
    endtask

    task automatic send(input int user_idx, input int drop_at, input int stop_en, output bit stopped);
        int idx = 0;
        int guard = 0;
        bit dropped = 1'b0;
        bit hs;
        stopped = 1'b0;
        while ((idx < tx_data.size() || stop_en > 0) && guard < LIMIT) begin
            @(negedge clk);
            if (guard == 0) start_cyc = cyc;
            if (stop_en > 0 && cap.size() >= stop_en) begin
                sif.tvalid = 1'b0;
                stopped = 1'b1;
                break;
            end
            hs = 1'b0;
            if (idx >= tx_data.size()) begin
                sif.tvalid = 1'b0;
                sif.tlast  = 1'b0;
                sif.tuser  = 1'b0;
            end else if (!dropped && drop_at >= 0 && idx == drop_at && sif.tready) begin
                sif.tvalid = 1'b0;
                dropped = 1'b1;
            end else begin
                sif.tvalid = 1'b1;
                sif.tdata  = tx_data[idx];
                sif.tlast  = (idx == tx_data.size() - 1);
                sif.tuser  = (idx == user_idx);
                hs = sif.tready;
            end
            @(posedge clk);
            if (hs) idx++;
            guard++;
        end
        if (guard >= LIMIT) begin
            n_checks++;
            n_err++;
            $display("FAIL send_timeout: got %0d bytes accepted, expected %0d", idx, tx_data.size());
        end
        if (!stopped) begin
            @(negedge clk);
            sif.tvalid = 1'b0;
            sif.tlast  = 1'b0;
            sif.tuser  = 1'b0;
        end
    endtask

    task automatic wait_pulses(input int target);
        int g = 0;
        while (done_cnt + err_cnt < target && g < LIMIT) begin
            @(negedge clk);
            g++;
        end
        if (g >= LIMIT) check("pulse_timeout", done_cnt + err_cnt, target);
    endtask

    task automatic run_frame(input int len, input u8 first, input int user_idx, input int drop_at,
                             input int exp_en, input string tag);
        int d0, e0, bad_b, bad_e;
        bit st;
        tx_data.delete();
        for (int i = 0; i < len; i++) tx_data.push_back(i == 0 ? first : u8'($urandom));
        build_model(user_idx, drop_at);
        cap.delete();
        cap_er.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        rise_cyc = -1;
        send(user_idx, drop_at, 0, st);
        wait_pulses(d0 + e0 + 1);
        repeat (IFG + 2) @(negedge clk);
        check({tag, "_en_cycles"}, cap.size(), (exp_en >= 0) ? exp_en : exp_b.size());
        bad_b = 0;
        bad_e = 0;
        for (int i = 0; i < cap.size() && i < exp_b.size(); i++) begin
            if (cap[i] !== exp_b[i] && bad_b == 0) bad_b = i + 1;
            if (cap_er[i] !== exp_er[i] && bad_e == 0) bad_e = i + 1;
        end
        check({tag, "_txd_first_bad_pos"}, bad_b, 0);
        check({tag, "_txer_first_bad_pos"}, bad_e, 0);
        check({tag, "_frame_done"}, done_cnt - d0, exp_err ? 0 : 1);
        check({tag, "_frame_err"}, err_cnt - e0, exp_err ? 1 : 0);
        check({tag, "_txen_latency"}, rise_cyc, start_cyc + 1);
        if (drop_at < 0 && cap.size() > 8)
            check({tag, "_crc_residue"}, crc32_of(cap, 8), 32'hDEBB20E3);
    endtask

    initial begin
        int len, r, uidx, didx, d0, e0, dd;
        bit st;
        sif.tvalid = 1'b0;
        sif.tdata  = 8'h00;
        sif.tlast  = 1'b0;
        sif.tuser  = 1'b0;

        vecs[0] = '{len: 1,   first: 8'hAB, user_idx: -1, drop_at: -1, exp_en: 72,  exp_err: 1'b0};
        vecs[1] = '{len: 100, first: 8'h00, user_idx: -1, drop_at: -1, exp_en: 112, exp_err: 1'b0};
        vecs[2] = '{len: 60,  first: 8'h11, user_idx: -1, drop_at: -1, exp_en: 72,  exp_err: 1'b0};
        vecs[3] = '{len: 59,  first: 8'h22, user_idx: -1, drop_at: -1, exp_en: 72,  exp_err: 1'b0};
        vecs[4] = '{len: 61,  first: 8'h33, user_idx: -1, drop_at: -1, exp_en: 73,  exp_err: 1'b0};
        vecs[5] = '{len: 64,  first: 8'h44, user_idx: 10, drop_at: -1, exp_en: 76,  exp_err: 1'b1};
        vecs[6] = '{len: 40,  first: 8'h55, user_idx: -1, drop_at: 20, exp_en: 29,  exp_err: 1'b1};

        repeat (3) @(negedge clk);
        check("rst_txd", gmii_txd, 8'h00);
        check("rst_tx_en", gmii_tx_en, 0);
        check("rst_tx_er", gmii_tx_er, 0);
        check("rst_tready", sif.tready, 0);
        check("rst_pulses", frame_done | frame_err, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < 7; v++) begin
            run_frame(vecs[v].len, vecs[v].first, vecs[v].user_idx, vecs[v].drop_at,
                      vecs[v].exp_en, $sformatf("vec%0d", v));
            check($sformatf("vec%0d_err_flag", v), err_cnt > 0 && exp_err, vecs[v].exp_err);
        end

        for (int n = 0; n < 8; n++) begin
            len  = int'($urandom_range(1, 130));
            r    = int'($urandom_range(0, 2));
            uidx = (r == 0) ? int'($urandom_range(0, len - 1)) : -1;
            didx = (r == 1) ? int'($urandom_range(0, len - 1)) : -1;
            run_frame(len, u8'($urandom), uidx, didx, -1, $sformatf("rnd%0d", n));
        end

        gaps.delete();
        d0 = done_cnt + err_cnt;
        dd = done_cnt;
        tx_data.delete();
        for (int i = 0; i < 64; i++) tx_data.push_back(u8'($urandom));
        send(-1, -1, 0, st);
        tx_data.delete();
        for (int i = 0; i < 64; i++) tx_data.push_back(u8'($urandom));
        send(-1, -1, 0, st);
        wait_pulses(d0 + 2);
        repeat (IFG + 2) @(negedge clk);
        check("b2b_gap", (gaps.size() >= 2) ? gaps[gaps.size() - 1] : -1, IFG);
        check("b2b_done", done_cnt - dd, 2);

        tx_data.delete();
        for (int i = 0; i < 60; i++) tx_data.push_back(u8'($urandom));
        cap.delete();
        cap_er.delete();
        d0 = done_cnt;
        e0 = err_cnt;
        send(-1, -1, 70, st);
        check("fcs_reached", st, 1);
        reset = 1'b1;
        @(negedge clk);
        check("fcsrst_txd", gmii_txd, 8'h00);
        check("fcsrst_tx_en", gmii_tx_en, 0);
        check("fcsrst_tx_er", gmii_tx_er, 0);
        check("fcsrst_tready", sif.tready, 0);
        check("fcsrst_state", dut.state_q, ST_IDLE);
        repeat (3) @(negedge clk);
        check("fcsrst_no_done", done_cnt - d0, 0);
        check("fcsrst_no_err", err_cnt - e0, 0);
        reset = 1'b0;
        run_frame(10, 8'h5A, -1, -1, 72, "postrst");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
